// File: rtl/fp_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_pkg
// Description : Shared types, flag indices and constants for the pipelined
//               floating-point multiplier (fp_mult_pipe).
// Revision    : 1.0 - initial release
// ============================================================================
package fp_mult_pkg;

    // Operand class after decoding; subnormals are folded into FP_ZERO.
    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    // Bit positions inside the {NV, OF, UF, NX} flag vector.
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;
    localparam int FLAG_W  = 4;

    // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
    function automatic logic [63:0] canonical_qnan(input int exp_w, input int man_w);
        logic [63:0] w_q;
        w_q = '0;
        for (int i = 0; i < exp_w; i++) begin
            w_q[man_w + i] = 1'b1;
        end
        w_q[man_w - 1] = 1'b1;
        return w_q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_operand_class.sv
`default_nettype none
// ============================================================================
// Module      : fp_operand_class
// Description : Combinational decode of one floating-point operand into its
//               class (zero / normal / inf / NaN) and sign. Subnormal
//               encodings are reported as zero (denormals-are-zero).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_operand_class
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
)(
    input  logic [EXP_W+MAN_W:0] i_op,
    output fp_class_e            o_cls,
    output logic                 o_sign
);

    logic w_exp_ones;
    logic w_exp_zero;
    logic w_man_nz;

    assign w_exp_ones = &i_op[EXP_W+MAN_W-1:MAN_W];
    assign w_exp_zero = ~|i_op[EXP_W+MAN_W-1:MAN_W];
    assign w_man_nz   = |i_op[MAN_W-1:0];
    assign o_sign     = i_op[EXP_W+MAN_W];

    // Exponent field selects the class; the mantissa only splits Inf from NaN.
    always_comb begin
        o_cls = FP_NORM;
        if (w_exp_ones) begin
            o_cls = w_man_nz ? FP_NAN : FP_INF;
        end else if (w_exp_zero) begin
            o_cls = FP_ZERO;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_pipe
// Description : Pipelined floating-point multiplier (default bfloat16) with
//               valid/ready handshakes, full backpressure, exception flags
//               {NV, OF, UF, NX}, DAZ inputs and FTZ results.
//               Build option FP_MULT_RNE_EN: when defined, results are
//               rounded to nearest-even; otherwise they are truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 7,
    parameter int LATENCY = 2   // 1..3 register stages
)(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   in_a_i,
    input  logic [EXP_W+MAN_W:0]   in_b_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [EXP_W+MAN_W:0]   out_result_o,
    output logic [FLAG_W-1:0]      out_flags_o
);

    localparam int c_w  = 1 + EXP_W + MAN_W;
    localparam int c_pw = 2 * (MAN_W + 1);
    localparam int c_ew = EXP_W + 2;
    localparam logic signed [c_ew-1:0] c_bias    = c_ew'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [c_ew-1:0] c_exp_max = c_ew'((1 << EXP_W) - 1);
    localparam logic [c_w-1:0]         c_qnan    = c_w'(canonical_qnan(EXP_W, MAN_W));

    // Payload carried from the classify/multiply stage to normalise/round.
    typedef struct packed {
        logic                   special;      // result already decided by class
        logic [c_w-1:0]         spec_result;
        logic [FLAG_W-1:0]      spec_flags;
        logic                   sign;
        logic signed [c_ew-1:0] exp_sum;      // ea + eb - bias
        logic [c_pw-1:0]        prod;         // full significand product
    } mid_t;

    logic [EXP_W-1:0] w_ea;
    logic [EXP_W-1:0] w_eb;
    logic [MAN_W-1:0] w_ma;
    logic [MAN_W-1:0] w_mb;
    fp_class_e        w_a_cls;
    fp_class_e        w_b_cls;
    logic             w_a_sign;
    logic             w_b_sign;
    mid_t             w_mid;

    assign w_ea = in_a_i[c_w-2:MAN_W];
    assign w_eb = in_b_i[c_w-2:MAN_W];
    assign w_ma = in_a_i[MAN_W-1:0];
    assign w_mb = in_b_i[MAN_W-1:0];

    fp_operand_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_a_class (
        .i_op   (in_a_i),
        .o_cls  (w_a_cls),
        .o_sign (w_a_sign)
    );

    fp_operand_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_b_class (
        .i_op   (in_b_i),
        .o_cls  (w_b_cls),
        .o_sign (w_b_sign)
    );

    // Classify/multiply stage: special-case resolution in priority order, plus exponent sum and product.
    always_comb begin
        w_mid         = '0;
        w_mid.sign    = w_a_sign ^ w_b_sign;
        w_mid.exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_bias;
        w_mid.prod    = {{(MAN_W+1){1'b0}}, 1'b1, w_ma} * {{(MAN_W+1){1'b0}}, 1'b1, w_mb};
        if (w_a_cls == FP_NAN || w_b_cls == FP_NAN) begin
            w_mid.special             = 1'b1;
            w_mid.spec_result         = c_qnan;
            w_mid.spec_flags[FLAG_NV] = 1'b1;
        end else if ((w_a_cls == FP_INF && w_b_cls == FP_ZERO) ||
                     (w_a_cls == FP_ZERO && w_b_cls == FP_INF)) begin
            w_mid.special             = 1'b1;
            w_mid.spec_result         = c_qnan;
            w_mid.spec_flags[FLAG_NV] = 1'b1;
        end else if (w_a_cls == FP_INF || w_b_cls == FP_INF) begin
            w_mid.special     = 1'b1;
            w_mid.spec_result = {w_mid.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_a_cls == FP_ZERO || w_b_cls == FP_ZERO) begin
            w_mid.special     = 1'b1;
            w_mid.spec_result = {w_mid.sign, {(c_w-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------------
    // Stage chain. Stage k advances when it is empty or its successor advances;
    // the final stage's successor is the consumer.
    // ------------------------------------------------------------------------
    mid_t                w_stage_in [LATENCY];
    logic [LATENCY-1:0]  w_valid;
    logic [LATENCY-1:0]  w_vin;
    logic [LATENCY:0]    w_adv;
    logic                r_out_valid;
    logic [c_w-1:0]      r_result;
    logic [FLAG_W-1:0]   r_flags;
    logic [c_w-1:0]      w_fin_result;
    logic [FLAG_W-1:0]   w_fin_flags;

    assign w_stage_in[0]  = w_mid;
    assign w_vin[0]       = in_valid_i;
    assign w_adv[LATENCY] = out_ready_i;
    assign in_ready_o     = w_adv[0];

    generate
        for (genvar k = 0; k < LATENCY; k++) begin : g_stage
            assign w_adv[k] = !w_valid[k] || w_adv[k+1];

            if (k > 0) begin : g_vin
                assign w_vin[k] = w_valid[k-1];
            end

            if (k < LATENCY - 1) begin : g_mid
                logic r_v;
                mid_t r_mid;

                // Retiming register: payload only loads with a valid operation.
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_v   <= 1'b0;
                        r_mid <= '0;
                    end else if (w_adv[k]) begin
                        r_v <= w_vin[k];
                        if (w_vin[k]) begin
                            r_mid <= w_stage_in[k];
                        end
                    end
                end

                assign w_valid[k]        = r_v;
                assign w_stage_in[k+1]   = r_mid;
            end else begin : g_last
                // Output register: holds result and flags while the consumer stalls.
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_out_valid <= 1'b0;
                        r_result    <= '0;
                        r_flags     <= '0;
                    end else if (w_adv[k]) begin
                        r_out_valid <= w_vin[k];
                        if (w_vin[k]) begin
                            r_result <= w_fin_result;
                            r_flags  <= w_fin_flags;
                        end
                    end
                end

                assign w_valid[k] = r_out_valid;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Normalise / round / pack, feeding the output register.
    // ------------------------------------------------------------------------
    mid_t                   w_last;
    logic                   w_msb;
    logic [c_pw-1:0]        w_norm;
    logic [MAN_W-1:0]       w_man;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_round_up;
    logic [MAN_W:0]         w_man_rnd;
    logic signed [c_ew-1:0] w_exp_pre;
    logic signed [c_ew-1:0] w_exp_rnd;

    assign w_last    = w_stage_in[LATENCY-1];
    assign w_msb     = w_last.prod[c_pw-1];
    // Left-justify so the hidden 1 always sits in the top bit.
    assign w_norm    = w_msb ? w_last.prod : (w_last.prod << 1);
    assign w_man     = w_norm[c_pw-2 -: MAN_W];
    assign w_guard   = w_norm[c_pw-2-MAN_W];
    assign w_sticky  = |w_norm[c_pw-3-MAN_W:0];
    assign w_exp_pre = w_last.exp_sum + $signed({{(c_ew-1){1'b0}}, w_msb});

`ifdef FP_MULT_RNE_EN
    assign w_round_up = w_guard && (w_sticky || w_man[0]);
`else
    assign w_round_up = 1'b0;
`endif

    // A carry out of the mantissa leaves the field at zero and bumps the exponent.
    assign w_man_rnd = {1'b0, w_man} + {{MAN_W{1'b0}}, w_round_up};
    assign w_exp_rnd = w_exp_pre + $signed({{(c_ew-1){1'b0}}, w_man_rnd[MAN_W]});

    // Final packing: special results pass through, then overflow, then flush-to-zero.
    always_comb begin
        w_fin_result          = {w_last.sign, w_exp_rnd[EXP_W-1:0], w_man_rnd[MAN_W-1:0]};
        w_fin_flags           = '0;
        w_fin_flags[FLAG_NX]  = w_guard | w_sticky;
        if (w_last.special) begin
            w_fin_result = w_last.spec_result;
            w_fin_flags  = w_last.spec_flags;
        end else if (w_exp_rnd >= c_exp_max) begin
            w_fin_result         = {w_last.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_fin_flags[FLAG_OF] = 1'b1;
            w_fin_flags[FLAG_NX] = 1'b1;
        end else if (w_exp_rnd[c_ew-1] || (w_exp_rnd == '0)) begin
            w_fin_result         = {w_last.sign, {(c_w-1){1'b0}}};
            w_fin_flags[FLAG_UF] = 1'b1;
            w_fin_flags[FLAG_NX] = 1'b1;
        end
    end

    assign out_valid_o  = r_out_valid;
    assign out_result_o = r_result;
    assign out_flags_o  = r_flags;

endmodule
`default_nettype wire
